// File: rtl/rx_header_parser_if.sv
// AXI-Stream bundle used for both the RX ingress stream and the S2MM payload stream.
interface rx_header_parser_if #(
    parameter int C_DATA_WIDTH = 32
);
    logic [C_DATA_WIDTH-1:0]   tdata;
    logic [C_DATA_WIDTH/8-1:0] tkeep;
    logic                      tvalid;
    logic                      tlast;
    logic                      tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rx_header_parser.sv
// RDMA RX ingress: parses the 5-word header, issues it when downstream is idle,
// forwards WRITE payloads to S2MM and drops everything else.
module rx_header_parser #(
    parameter int                         C_DATA_WIDTH             = 32,
    parameter int                         RDMA_OPCODE_WIDTH        = 8,
    parameter int                         RDMA_ADDR_WIDTH          = 64,
    parameter int                         RDMA_RKEY_WIDTH          = 32,
    parameter int                         RDMA_LENGTH_WIDTH        = 32,
    parameter int                         OFFSET_LENGTH            = 16,
    parameter logic [RDMA_OPCODE_WIDTH-1:0] RDMA_OPCODE_WRITE_FIRST  = 8'h06,
    parameter logic [RDMA_OPCODE_WIDTH-1:0] RDMA_OPCODE_WRITE_MIDDLE = 8'h07,
    parameter logic [RDMA_OPCODE_WIDTH-1:0] RDMA_OPCODE_WRITE_LAST   = 8'h08,
    parameter logic [RDMA_OPCODE_WIDTH-1:0] RDMA_OPCODE_WRITE_ONLY   = 8'h0A,
    parameter logic [RDMA_OPCODE_WIDTH-1:0] RDMA_OPCODE_WRITE_TEST   = 8'h01
) (
    input  logic                          aclk,
    input  logic                          areset,
    rx_header_parser_if.slave             s_axis,
    rx_header_parser_if.master            m_axis,
    input  logic                          hdr_ready,
    output logic                          header_valid,
    output logic [RDMA_OPCODE_WIDTH-1:0]  rdma_opcode,
    output logic [RDMA_ADDR_WIDTH-1:0]    rdma_remote_addr,
    output logic [RDMA_RKEY_WIDTH-1:0]    rdma_rkey,
    output logic [RDMA_LENGTH_WIDTH-1:0]  rdma_length,
    output logic [OFFSET_LENGTH-1:0]      fragment_offset,
    output logic                          len_err,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   drop_count
);

    localparam int KEEP_W = C_DATA_WIDTH / 8;

    typedef enum logic [1:0] {HDR, ISSUE, PAYLOAD, DROP} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [2:0]  hdr_idx;
    logic [31:0] byte_cnt;
    logic [31:0] byte_total;
    logic [2:0]  beat_bytes;
    logic        s_hs;
    logic        runt;
    logic        opcode_is_write;

    function automatic logic [2:0] popcount(input logic [KEEP_W-1:0] k);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) c = c + 3'(k[i]);
        return c;
    endfunction

    function automatic logic is_write(input logic [RDMA_OPCODE_WIDTH-1:0] op);
        return op inside {RDMA_OPCODE_WRITE_FIRST, RDMA_OPCODE_WRITE_MIDDLE,
                          RDMA_OPCODE_WRITE_LAST, RDMA_OPCODE_WRITE_ONLY,
                          RDMA_OPCODE_WRITE_TEST};
    endfunction

    assign s_hs            = s_axis.tvalid & s_axis.tready;
    assign beat_bytes      = popcount(s_axis.tkeep);
    assign byte_total      = byte_cnt + 32'(beat_bytes);
    assign opcode_is_write = is_write(rdma_opcode);

    // Stream ports: payload is a zero-bubble combinational pass-through
    assign m_axis.tdata = s_axis.tdata;
    assign m_axis.tkeep = s_axis.tkeep;
    assign m_axis.tlast = s_axis.tlast;

    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        case (state)
            HDR, DROP: s_axis.tready = run;
            PAYLOAD: begin
                s_axis.tready = m_axis.tready;
                m_axis.tvalid = s_axis.tvalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        header_valid = 1'b0;
        runt         = 1'b0;
        case (state)
            HDR: begin
                if (s_hs) begin
                    if (s_axis.tlast)       runt      = 1'b1;
                    else if (hdr_idx == 3'd4) state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                header_valid = hdr_ready;
                if (hdr_ready) state_nxt = opcode_is_write ? PAYLOAD : DROP;
            end
            PAYLOAD, DROP: begin
                if (s_hs && s_axis.tlast) state_nxt = HDR;
            end
            default: state_nxt = HDR;
        endcase
    end

    // Control: beat index, counters and length check
    always_ff @(posedge aclk) begin
        if (areset) begin
            run        <= 1'b0;
            hdr_idx    <= '0;
            byte_cnt   <= '0;
            len_err    <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            run     <= 1'b1;
            len_err <= 1'b0;
            if (state == HDR && s_hs)
                hdr_idx <= (s_axis.tlast || hdr_idx == 3'd4) ? 3'd0 : hdr_idx + 3'd1;
            if (runt || (header_valid && !opcode_is_write))
                drop_count <= drop_count + 32'd1;
            if (header_valid) begin
                pkt_count <= pkt_count + 32'd1;
                byte_cnt  <= '0;
            end
            if (state == PAYLOAD && s_hs) begin
                byte_cnt <= byte_total;
                if (s_axis.tlast) len_err <= (byte_total != 32'(rdma_length));
            end
        end
    end

    // Header field capture, one register group per header word
    always_ff @(posedge aclk) begin
        if (areset) begin
            rdma_opcode      <= '0;
            fragment_offset  <= '0;
            rdma_remote_addr <= '0;
            rdma_rkey        <= '0;
            rdma_length      <= '0;
        end else if (state == HDR && s_hs) begin
            case (hdr_idx)
                3'd0: begin
                    rdma_opcode     <= s_axis.tdata[31:24];
                    fragment_offset <= s_axis.tdata[15:0];
                end
                3'd1:    rdma_remote_addr[63:32] <= s_axis.tdata;
                3'd2:    rdma_remote_addr[31:0]  <= s_axis.tdata;
                3'd3:    rdma_rkey               <= s_axis.tdata;
                3'd4:    rdma_length             <= s_axis.tdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_header_parser.sv
// Directed bench for rx_header_parser: header parse, stall, drop, runt, length
// check, back-pressure and mid-payload reset.
module tb_rx_header_parser;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        hdr_ready = 1'b1;
    logic        header_valid;
    logic [7:0]  rdma_opcode;
    logic [63:0] rdma_remote_addr;
    logic [31:0] rdma_rkey;
    logic [31:0] rdma_length;
    logic [15:0] fragment_offset;
    logic        len_err;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;

    rx_header_parser_if s_if ();
    rx_header_parser_if m_if ();

    rx_header_parser dut (
        .aclk             (aclk),
        .areset           (areset),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .hdr_ready        (hdr_ready),
        .header_valid     (header_valid),
        .rdma_opcode      (rdma_opcode),
        .rdma_remote_addr (rdma_remote_addr),
        .rdma_rkey        (rdma_rkey),
        .rdma_length      (rdma_length),
        .fragment_offset  (fragment_offset),
        .len_err          (len_err),
        .pkt_count        (pkt_count),
        .drop_count       (drop_count)
    );

    always #5 aclk = ~aclk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitors sample mid-cycle, so a high valid/ready pair means a transfer at the next edge
    logic [31:0] mq_data[$];
    logic        mq_last[$];
    int          hv_cnt = 0, le_cnt = 0, mv_cnt = 0;
    logic [7:0]  cap_op;
    logic [63:0] cap_addr;
    logic [31:0] cap_rkey, cap_len;
    logic [15:0] cap_frag;

    always @(negedge aclk) begin
        if (m_if.tvalid === 1'b1) mv_cnt <= mv_cnt + 1;
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            mq_data.push_back(m_if.tdata);
            mq_last.push_back(m_if.tlast);
        end
        if (header_valid === 1'b1) begin
            hv_cnt   <= hv_cnt + 1;
            cap_op   <= rdma_opcode;
            cap_addr <= rdma_remote_addr;
            cap_rkey <= rdma_rkey;
            cap_len  <= rdma_length;
            cap_frag <= fragment_offset;
        end
        if (len_err === 1'b1) le_cnt <= le_cnt + 1;
    end

    logic rnd_en = 1'b0;
    always @(posedge aclk) begin
        #1;
        m_if.tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic put(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_if.tready === 1'b1) break;
            n++;
            if (n > 500) begin
                chk("put_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [63:0] addr,
                            input logic [15:0] frag, input logic [31:0] rkey,
                            input logic [31:0] len);
        put({op, 8'h00, frag}, 4'hF, 1'b0);
        put(addr[63:32], 4'hF, 1'b0);
        put(addr[31:0], 4'hF, 1'b0);
        put(rkey, 4'hF, 1'b0);
        put(len, 4'hF, 1'b0);
    endtask

    task automatic send_payload(input int n, input logic [3:0] last_keep, input logic [31:0] base);
        for (int i = 0; i < n; i++)
            put(base + 32'(i), (i == n - 1) ? last_keep : 4'hF, i == n - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hv0, le0, mq0, mv0, bad;
        logic stall_bad;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_hv", header_valid, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_len", rdma_length, 0);
        chk("rst_addr", rdma_remote_addr, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rdy_first_cycle", s_if.tready, 0);
        @(negedge aclk);
        chk("rdy_after_reset", s_if.tready, 1);
        idle(1);

        // Test 1: WRITE_ONLY, 2 full beats
        hv0 = hv_cnt; le0 = le_cnt; mq0 = mq_data.size();
        send_hdr(8'h0A, 64'h0000_0000_1000_0000, 16'h0000, 32'h1234_5678, 32'd8);
        send_payload(2, 4'hF, 32'hA000_0000);
        idle(3);
        chk("t1_hv_cnt", 64'(hv_cnt - hv0), 1);
        chk("t1_op", cap_op, 8'h0A);
        chk("t1_addr", cap_addr, 64'h0000_0000_1000_0000);
        chk("t1_rkey", cap_rkey, 32'h1234_5678);
        chk("t1_len", cap_len, 32'd8);
        chk("t1_beats", 64'(mq_data.size() - mq0), 2);
        chk("t1_d0", mq_data[mq0], 32'hA000_0000);
        chk("t1_d1", mq_data[mq0 + 1], 32'hA000_0001);
        chk("t1_l0", mq_last[mq0], 0);
        chk("t1_l1", mq_last[mq0 + 1], 1);
        chk("t1_len_err", 64'(le_cnt - le0), 0);
        chk("t1_pkt", pkt_count, 1);

        // Test 2: downstream busy for 10 cycles after W4
        hdr_ready = 1'b0;
        hv0 = hv_cnt; mq0 = mq_data.size();
        send_hdr(8'h0A, 64'h0000_0000_1000_0000, 16'h0000, 32'h1234_5678, 32'd8);
        stall_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            stall_bad = stall_bad | s_if.tready | header_valid;
        end
        chk("t2_stalled", stall_bad, 0);
        @(posedge aclk);
        #1 hdr_ready = 1'b1;
        @(negedge aclk);
        chk("t2_hv_on_ready", header_valid, 1);
        send_payload(2, 4'hF, 32'hB000_0000);
        idle(3);
        chk("t2_hv_cnt", 64'(hv_cnt - hv0), 1);
        chk("t2_beats", 64'(mq_data.size() - mq0), 2);
        chk("t2_d1", mq_data[mq0 + 1], 32'hB000_0001);
        chk("t2_pkt", pkt_count, 2);

        // Test 3: non-write opcode is issued but its payload is dropped
        hv0 = hv_cnt; mv0 = mv_cnt;
        send_hdr(8'h04, 64'h0000_0000_2000_0000, 16'h0000, 32'h1111_2222, 32'd12);
        send_payload(3, 4'hF, 32'hC000_0000);
        idle(3);
        chk("t3_hv_cnt", 64'(hv_cnt - hv0), 1);
        chk("t3_no_mvalid", 64'(mv_cnt - mv0), 0);
        chk("t3_drop", drop_count, 1);
        mq0 = mq_data.size();
        send_hdr(8'h06, 64'h0000_0001_2345_6780, 16'h0040, 32'h3333_4444, 32'd4);
        send_payload(1, 4'hF, 32'hC100_0000);
        idle(3);
        chk("t3_next_op", cap_op, 8'h06);
        chk("t3_next_addr", cap_addr, 64'h0000_0001_2345_6780);
        chk("t3_next_frag", cap_frag, 16'h0040);
        chk("t3_next_beat", mq_data[mq0], 32'hC100_0000);
        chk("t3_pkt", pkt_count, 4);

        // Test 4: runt packet ending on W2
        hv0 = hv_cnt; le0 = le_cnt;
        put(32'h0A00_0000, 4'hF, 1'b0);
        put(32'h0000_0000, 4'hF, 1'b0);
        put(32'h5000_0000, 4'hF, 1'b1);
        idle(3);
        chk("t4_no_hv", 64'(hv_cnt - hv0), 0);
        chk("t4_drop", drop_count, 2);
        mq0 = mq_data.size();
        send_hdr(8'h08, 64'hDEAD_BEEF_0000_1000, 16'h0123, 32'h5555_6666, 32'd6);
        send_payload(2, 4'h3, 32'hD000_0000);
        idle(3);
        chk("t4_op", cap_op, 8'h08);
        chk("t4_addr", cap_addr, 64'hDEAD_BEEF_0000_1000);
        chk("t4_frag", cap_frag, 16'h0123);
        chk("t4_rkey", cap_rkey, 32'h5555_6666);
        chk("t4_beats", 64'(mq_data.size() - mq0), 2);
        chk("t4_len_err", 64'(le_cnt - le0), 0);
        chk("t4_pkt", pkt_count, 5);

        // Test 5: byte-accurate length check with a partial last beat
        le0 = le_cnt;
        send_hdr(8'h0A, 64'h0000_0000_3000_0000, 16'h0000, 32'h7777_8888, 32'd10);
        send_payload(3, 4'h3, 32'hE000_0000);
        idle(3);
        chk("t5_len10_ok", 64'(le_cnt - le0), 0);
        send_hdr(8'h0A, 64'h0000_0000_3000_0000, 16'h0000, 32'h7777_8888, 32'd12);
        send_payload(3, 4'h3, 32'hE100_0000);
        idle(3);
        chk("t5_len12_err", 64'(le_cnt - le0), 1);
        chk("t5_drop", drop_count, 2);

        // Test 6: random back-pressure over 8 beats, then reset mid-payload
        le0 = le_cnt; mq0 = mq_data.size();
        rnd_en = 1'b1;
        send_hdr(8'h07, 64'h0000_0000_4000_0000, 16'h0000, 32'h9999_AAAA, 32'd32);
        send_payload(8, 4'hF, 32'hF000_0000);
        rnd_en = 1'b0;
        idle(3);
        chk("t6_beats", 64'(mq_data.size() - mq0), 8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (mq_data.size() > mq0 + i &&
                (mq_data[mq0 + i] !== 32'hF000_0000 + 32'(i) || mq_last[mq0 + i] !== (i == 7)))
                bad++;
        chk("t6_order", 64'(bad), 0);
        chk("t6_len_err", 64'(le_cnt - le0), 0);
        chk("t6_pkt", pkt_count, 8);

        send_hdr(8'h0A, 64'h0000_0000_5000_0000, 16'h0007, 32'hBBBB_CCCC, 32'd16);
        put(32'h1111_0000, 4'hF, 1'b0);
        put(32'h1111_0001, 4'hF, 1'b0);
        s_if.tvalid = 1'b1;
        areset = 1'b1;
        @(posedge aclk);
        #1 s_if.tvalid = 1'b0;
        @(negedge aclk);
        chk("t6r_s_tready", s_if.tready, 0);
        chk("t6r_m_tvalid", m_if.tvalid, 0);
        chk("t6r_hv", header_valid, 0);
        chk("t6r_pkt", pkt_count, 0);
        chk("t6r_drop", drop_count, 0);
        chk("t6r_op", rdma_opcode, 0);
        chk("t6r_addr", rdma_remote_addr, 0);
        chk("t6r_len", rdma_length, 0);
        chk("t6r_frag", fragment_offset, 0);
        chk("t6r_len_err", len_err, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        idle(2);
        send_hdr(8'h0A, 64'h0000_0000_6000_0000, 16'h0000, 32'hDDDD_EEEE, 32'd4);
        send_payload(1, 4'hF, 32'h2222_0000);
        idle(3);
        chk("t6r_post_len", cap_len, 32'd4);
        chk("t6r_post_pkt", pkt_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
